// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-to-hazard-controller signal bundle
interface hazard_ctrl_if;
  // ID-stage operand usage
  logic [4:0]  rs1_id;
  logic [4:0]  rs2_id;
  logic        rs1_used_id;
  logic        rs2_used_id;
  // EX-stage status
  logic [4:0]  rd_ex;
  logic        memread_ex;
  logic        branch_taken_ex;
  logic        mc_start_ex;
  // MEM-stage data access
  logic        mem_req;
  logic        mem_ready;
  // stop/flush controls for PC, IF/ID, ID/EX, EX/MEM
  logic        stop_pc;
  logic        stop_id;
  logic        flush_id;
  logic        stop_ex;
  logic        flush_ex;
  logic        stop_mem;
  logic        flush_mem;
  // performance counters
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  // pipeline side: reports hazards, consumes controls
  modport master (
    output rs1_id, rs2_id, rs1_used_id, rs2_used_id,
    output rd_ex, memread_ex, branch_taken_ex, mc_start_ex,
    output mem_req, mem_ready,
    input  stop_pc, stop_id, flush_id, stop_ex, flush_ex, stop_mem, flush_mem,
    input  stall_cycles, flush_count
  );

  // controller side
  modport slave (
    input  rs1_id, rs2_id, rs1_used_id, rs2_used_id,
    input  rd_ex, memread_ex, branch_taken_ex, mc_start_ex,
    input  mem_req, mem_ready,
    output stop_pc, stop_id, flush_id, stop_ex, flush_ex, stop_mem, flush_mem,
    output stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
module hazard_ctrl #(
  parameter int MC_LATENCY = 32,
  parameter int CNT_W      = 8
) (
  input logic          clk_cpu,
  input logic          rst_cpu,
  hazard_ctrl_if.slave i_hz
);

  typedef enum logic {
    ST_RUN     = 1'b0,
    ST_MC_BUSY = 1'b1
  } state_t;

  // The start cycle is itself a stall, so the busy phase counts down
  // MC_LATENCY-2 further stall cycles and then releases for one cycle.
  localparam logic [CNT_W-1:0] MC_LOAD = CNT_W'(MC_LATENCY - 2);

  state_t           r_state;
  logic [CNT_W-1:0] r_mc_cnt;
  logic [31:0]      r_stall_cycles;
  logic [31:0]      r_flush_count;

  logic w_mem_wait;
  logic w_run;
  logic w_mc_stall;
  logic w_branch;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;

  logic w_stop_pc;
  logic w_stop_id;
  logic w_flush_id;
  logic w_stop_ex;
  logic w_flush_ex;
  logic w_stop_mem;
  logic w_flush_mem;

  // Hazard detection terms
  assign w_mem_wait = i_hz.mem_req & ~i_hz.mem_ready;
  assign w_run      = (r_state == ST_RUN);

  // In the final busy cycle (count exhausted) mc_start_ex is still high
  // because the op is leaving EX; it must not be taken as a new start.
  assign w_mc_stall = (w_run & i_hz.mc_start_ex) |
                      ((r_state == ST_MC_BUSY) & (r_mc_cnt != '0));

  assign w_branch   = w_run & i_hz.branch_taken_ex;

  assign w_rs1_hit  = i_hz.rs1_used_id & (i_hz.rs1_id == i_hz.rd_ex);
  assign w_rs2_hit  = i_hz.rs2_used_id & (i_hz.rs2_id == i_hz.rd_ex);
  // x0 is never written, so a load to x0 cannot create a dependency
  assign w_load_use = w_run & i_hz.memread_ex & (i_hz.rd_ex != 5'd0) &
                      (w_rs1_hit | w_rs2_hit);

  // Prioritised Mealy control outputs, all quiet while in reset
  always_comb begin
    w_stop_pc   = 1'b0;
    w_stop_id   = 1'b0;
    w_flush_id  = 1'b0;
    w_stop_ex   = 1'b0;
    w_flush_ex  = 1'b0;
    w_stop_mem  = 1'b0;
    w_flush_mem = 1'b0;
    if (!rst_cpu) begin
      if (w_mem_wait) begin
        // freeze everything up to and including EX/MEM
        w_stop_pc  = 1'b1;
        w_stop_id  = 1'b1;
        w_stop_ex  = 1'b1;
        w_stop_mem = 1'b1;
      end else if (w_mc_stall) begin
        // hold the op in EX and send bubbles into MEM
        w_stop_pc   = 1'b1;
        w_stop_id   = 1'b1;
        w_stop_ex   = 1'b1;
        w_flush_mem = 1'b1;
      end else if (w_branch) begin
        // wrong-path IF and ID instructions are discarded, PC redirects
        w_flush_id = 1'b1;
        w_flush_ex = 1'b1;
      end else if (w_load_use) begin
        // hold IF/ID one cycle and inject a bubble behind the load
        w_stop_pc  = 1'b1;
        w_stop_id  = 1'b1;
        w_flush_ex = 1'b1;
      end
    end
  end

  // Multi-cycle op tracking; a memory wait freezes the countdown
  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      r_state  <= ST_RUN;
      r_mc_cnt <= '0;
    end else if (!w_mem_wait) begin
      case (r_state)
        ST_RUN: begin
          if (i_hz.mc_start_ex) begin
            r_state  <= ST_MC_BUSY;
            r_mc_cnt <= MC_LOAD;
          end
        end
        ST_MC_BUSY: begin
          if (r_mc_cnt != '0) begin
            r_mc_cnt <= r_mc_cnt - 1'b1;
          end else begin
            r_state <= ST_RUN;
          end
        end
        default: begin
          r_state  <= ST_RUN;
          r_mc_cnt <= '0;
        end
      endcase
    end
  end

  // Stall and flush performance counters, free-running with wrap
  always_ff @(posedge clk_cpu or posedge rst_cpu) begin
    if (rst_cpu) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (w_stop_pc) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_flush_id) begin
        r_flush_count <= r_flush_count + 32'd1;
      end
    end
  end

  assign i_hz.stop_pc      = w_stop_pc;
  assign i_hz.stop_id      = w_stop_id;
  assign i_hz.flush_id     = w_flush_id;
  assign i_hz.stop_ex      = w_stop_ex;
  assign i_hz.flush_ex     = w_flush_ex;
  assign i_hz.stop_mem     = w_stop_mem;
  assign i_hz.flush_mem    = w_flush_mem;
  assign i_hz.stall_cycles = r_stall_cycles;
  assign i_hz.flush_count  = r_flush_count;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central stall/flush controller for the 5-stage RISC-V pipeline (IF, ID, EX, MEM, WB).
- Drives the stop and flush inputs of the PC register and of the IF/ID, ID/EX and EX/MEM pipeline registers.
- Detects load-use hazards, taken branches/jumps resolved in EX, multi-cycle EX operations (mul/div) and data-memory wait states.
- Keeps performance counters of stall and flush cycles.

Parameters:
MC_LATENCY, 32, total cycles a multi-cycle op occupies EX; legal range 2..255.
CNT_W, 8, width of the multi-cycle down-counter; must satisfy 2^CNT_W > MC_LATENCY.

Ports:
clk_cpu  in  1  clock; all registers update on rising edge.
rst_cpu  in  1  reset; asynchronous, active-high.
rs1_id  in  5  rs1 field of the instruction in ID.
rs2_id  in  5  rs2 field of the instruction in ID.
rs1_used_id  in  1  the ID instruction reads rs1.
rs2_used_id  in  1  the ID instruction reads rs2.
rd_ex  in  5  destination register of the instruction in EX.
memread_ex  in  1  the EX instruction is a load.
branch_taken_ex  in  1  a branch/jump in EX redirects the PC this cycle.
mc_start_ex  in  1  the EX instruction is a multi-cycle op; held high while that op sits in EX.
mem_req  in  1  MEM stage has an outstanding data access.
mem_ready  in  1  data memory completes the access this cycle.
stop_pc  out  1  hold the PC.
stop_id  out  1  hold IF/ID (feeds the IF/ID stop input).
flush_id  out  1  bubble IF/ID (feeds the IF/ID flush input).
stop_ex  out  1  hold ID/EX.
flush_ex  out  1  bubble ID/EX.
stop_mem  out  1  hold EX/MEM.
flush_mem  out  1  bubble EX/MEM.
stall_cycles  out  32  count of cycles with stop_pc=1; wraps.
flush_count  out  32  count of cycles with flush_id=1; wraps.

Behaviour:
- Reset (asynchronous, rst_cpu=1):
  - FSM goes to RUN; mc_cnt=0; stall_cycles=0; flush_count=0.
  - All seven control outputs are forced 0 while rst_cpu=1.
- FSM states are RUN and MC_BUSY. Control outputs are combinational (Mealy) from the state, mc_cnt and current inputs, so a stall takes effect in the same cycle. Any output not listed for a case is 0.
- Priority, highest first:
  1. MEM wait.
  2. MC_BUSY / multi-cycle start.
  3. Branch flush.
  4. Load-use.
- MEM wait: mem_req=1 and mem_ready=0, in any state.
  - stop_pc, stop_id, stop_ex and stop_mem are 1; no flush is asserted.
  - FSM state and mc_cnt are held.
  - Pending branch and load-use conditions are re-evaluated after the wait ends.
- RUN with mc_start_ex=1:
  - stop_pc, stop_id, stop_ex and flush_mem are 1.
  - Load mc_cnt = MC_LATENCY-2; next state is MC_BUSY.
- MC_BUSY with mc_cnt != 0:
  - Same outputs as the multi-cycle start.
  - Decrement mc_cnt.
- MC_BUSY with mc_cnt == 0:
  - No stall; the op advances out of EX.
  - mc_start_ex is ignored this cycle; next state is RUN.
- Net multi-cycle effect: stalls last exactly MC_LATENCY-1 cycles, starting in the mc_start_ex cycle, and the op occupies EX for MC_LATENCY cycles.
- Branch flush: RUN with branch_taken_ex=1 gives flush_id=1 and flush_ex=1.
  - No PC stop, so the redirected PC loads.
  - Overrides a simultaneous load-use condition, because the ID instruction is on the wrong path.
- Load-use: RUN, memread_ex=1, rd_ex != 0, and either (rs1_used_id and rs1_id==rd_ex) or (rs2_used_id and rs2_id==rd_ex).
  - Gives stop_pc=1, stop_id=1, flush_ex=1 for one cycle.
  - No state is needed, because the load moves to MEM next cycle.
- A hazard on x0 never stalls.
- Counters:
  - stall_cycles increments on every clock with stop_pc=1.
  - flush_count increments on every clock with flush_id=1.
  - Both wrap from 2^32-1 to 0.
- Reset asserted during MC_BUSY aborts the op: next cycle is RUN with mc_cnt=0.

Test Plan:
- Load-use: memread_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 for one cycle -> stop_pc=stop_id=flush_ex=1 for exactly that cycle; stall_cycles 0->1. Repeat with rd_ex=0 -> no stall.
- Branch: branch_taken_ex=1 for one cycle -> flush_id=flush_ex=1, stop_pc=0; flush_count=1. Same cycle also satisfying load-use -> still only flush, no stop.
- Multi-cycle, MC_LATENCY=4: mc_start_ex=1 held 4 cycles -> stop_pc/stop_id/stop_ex/flush_mem=1 in cycles 1-3, all 0 in cycle 4; FSM back in RUN; stall_cycles=3; mc_start_ex high in cycle 4 does not restart.
- MEM wait inside MC_BUSY (MC_LATENCY=4): mem_req=1, mem_ready=0 for 2 cycles starting at cycle 2 -> all four stops =1, flush_mem=0, mc_cnt frozen; total stalled cycles = 5.
- Reset mid-op: assert rst_cpu during MC_BUSY -> outputs 0 immediately, counters 0, FSM RUN; a new mc_start_ex after release gives the full MC_LATENCY-1 stall.
